// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter: FSM state encoding,
// owner-index width calculation and the round-robin pick function.
package tristate_bus_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  // Widest channel count the pick function supports.
  localparam int MAX_CH = 64;
  localparam int IDX_W  = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic int calc_ow(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set request at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                    input int unsigned ptr,
                                    input int unsigned n);
    pick_t       res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = (ptr + k) % n;
      if (k < n && !res.found && req[idx[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant handshake between the channels and the arbiter.
interface tristate_bus_arbiter_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  import tristate_bus_pkg::*;

  localparam int OW = calc_ow(N_CH);

  logic                  enable;
  logic [N_CH-1:0]       req;
  logic [N_CH*WIDTH-1:0] data_in;
  logic [N_CH-1:0]       grant;
  logic [OW-1:0]         owner;
  logic                  bus_valid;
  logic                  turnaround;

  modport master (
    input  enable, req, data_in,
    output grant, owner, bus_valid, turnaround
  );

  modport slave (
    output enable, req, data_in,
    input  grant, owner, bus_valid, turnaround
  );

endinterface

// File: rtl/tristate_bus_arbiter_driver.sv
// One channel's tri-state output stage onto the shared bus.
module tristate_driver #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             oe_i,
  output tri   [WIDTH-1:0] out_o
);

  assign out_o = oe_i ? in_i : {WIDTH{1'bz}};

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbitration for a shared tri-state bus, with a hold limit
// and a high-Z turnaround gap so two drivers are never enabled together.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  tristate_bus_arbiter_if.master  bus,
  output tri   [WIDTH-1:0]        bus_line
);

  localparam int OW = calc_ow(N_CH);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  state_e          state_q;
  logic [N_CH-1:0] grant_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   rr_ptr_q;
  logic [HW-1:0]   hold_cnt_q;
  logic [TW-1:0]   turn_cnt_q;
  logic            bus_valid_q;
  logic            turnaround_q;

  logic [MAX_CH-1:0] req_ext;
  pick_t             pick;
  logic [OW-1:0]     rr_ptr_d;
  logic              release_d;

  always_comb begin
    req_ext            = '0;
    req_ext[N_CH-1:0]  = bus.req;
    pick               = rr_pick(req_ext, 32'(rr_ptr_q), N_CH);
    rr_ptr_d           = (owner_q == OW'(N_CH - 1)) ? '0 : owner_q + 1'b1;
    release_d          = !bus.req[owner_q] || (hold_cnt_q == HW'(MAX_HOLD)) || !bus.enable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      turn_cnt_q   <= '0;
      bus_valid_q  <= 1'b0;
      turnaround_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable && pick.found) begin
            state_q     <= GRANT;
            grant_q     <= N_CH'(1) << pick.idx;
            owner_q     <= OW'(pick.idx);
            hold_cnt_q  <= HW'(1);
            bus_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q      <= TURN;
            grant_q      <= '0;
            bus_valid_q  <= 1'b0;
            turnaround_q <= 1'b1;
            rr_ptr_q     <= rr_ptr_d;
            turn_cnt_q   <= TW'(1);
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        TURN: begin
          // rr_ptr_q was already advanced on entry, so the pick here rotates.
          if (turn_cnt_q == TW'(TURN_CYC)) begin
            turnaround_q <= 1'b0;
            if (bus.enable && pick.found) begin
              state_q     <= GRANT;
              grant_q     <= N_CH'(1) << pick.idx;
              owner_q     <= OW'(pick.idx);
              hold_cnt_q  <= HW'(1);
              bus_valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            turn_cnt_q <= turn_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          grant_q      <= '0;
          bus_valid_q  <= 1'b0;
          turnaround_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner      = owner_q;
  assign bus.bus_valid  = bus_valid_q;
  assign bus.turnaround = turnaround_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_drv
    tristate_driver #(.WIDTH(WIDTH)) u_drv (
      .in_i  (bus.data_in[i*WIDTH +: WIDTH]),
      .oe_i  (grant_q[i]),
      .out_o (bus_line)
    );
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: expected per-cycle outputs are queued
// when stimulus is applied and popped after the following clock edge.
module tb_tristate_bus_arbiter;
  import tristate_bus_pkg::*;

  localparam int NCh   = 4;
  localparam int Width = 8;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       turnaround;
    string      tag;
  } expect_t;

  logic clk;
  logic rst;
  tri [Width-1:0] busLine;

  tristate_bus_arbiter_if #(.N_CH(NCh), .WIDTH(Width)) busIf ();

  tristate_bus_arbiter #(.N_CH(NCh), .WIDTH(Width), .MAX_HOLD(4), .TURN_CYC(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (busIf.master),
    .bus_line (busLine)
  );

  expect_t scoreboard[$];
  int testCount = 0;
  int failCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous invariants, sampled on the falling edge.
  always @(negedge clk) begin
    testCount++;
    assert ($onehot0(busIf.grant) && (busIf.bus_valid === (|busIf.grant))) else begin
      failCount++;
      $error("[TB] FAIL invariant: grant=%b bus_valid=%b", busIf.grant, busIf.bus_valid);
    end
    if (busIf.bus_valid === 1'b1) begin
      testCount++;
      assert (!$isunknown(busLine)) else begin
        failCount++;
        $error("[TB] FAIL busNoX: observed %h", busLine);
      end
    end
  end

  task automatic checkOutput();
    expect_t    e;
    logic [7:0] expBus;
    logic       expValid;
    e        = scoreboard.pop_front();
    expValid = |e.grant;
    expBus   = 8'bz;
    for (int i = 0; i < NCh; i++)
      if (e.grant[i]) expBus = 8'hA0 + 8'(i);

    testCount++;
    assert (busIf.grant === e.grant) else begin
      failCount++;
      $error("[TB] FAIL %s grant: observed %b expected %b", e.tag, busIf.grant, e.grant);
    end
    testCount++;
    assert (busIf.owner === e.owner) else begin
      failCount++;
      $error("[TB] FAIL %s owner: observed %0d expected %0d", e.tag, busIf.owner, e.owner);
    end
    testCount++;
    assert (busIf.bus_valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s bus_valid: observed %b expected %b", e.tag, busIf.bus_valid, expValid);
    end
    testCount++;
    assert (busIf.turnaround === e.turnaround) else begin
      failCount++;
      $error("[TB] FAIL %s turnaround: observed %b expected %b", e.tag, busIf.turnaround, e.turnaround);
    end
    testCount++;
    assert (busLine === expBus) else begin
      failCount++;
      $error("[TB] FAIL %s bus_line: observed %h expected %h", e.tag, busLine, expBus);
    end
  endtask

  // Drive inputs, queue the state expected after the next edge, then check it.
  task automatic applyStimulus(input logic [3:0] reqVal, input logic enVal,
                               input logic [3:0] expGrant, input logic [1:0] expOwner,
                               input logic expTurn, input string tag);
    expect_t e;
    busIf.req    = reqVal;
    busIf.enable = enVal;
    e.grant      = expGrant;
    e.owner      = expOwner;
    e.turnaround = expTurn;
    e.tag        = tag;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyReset(input string tag);
    expect_t e;
    rst          = 1'b1;
    e.grant      = 4'b0000;
    e.owner      = 2'd0;
    e.turnaround = 1'b0;
    e.tag        = tag;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    busIf.enable  = 1'b0;
    busIf.req     = '0;
    busIf.data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(posedge clk);
    #1;
    applyReset("reset");

    // Single requester: 4 cycles driving, 1 turnaround, repeated.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) applyStimulus(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "single");
      applyStimulus(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1, "singleTurn");
    end
    applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "toIdle");

    // All request: owners rotate 0,1,2,3,0.
    applyReset("reset2");
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 4; c++)
        applyStimulus(4'b1111, 1'b1, 4'b0001 << (o % 4), 2'(o % 4), 1'b0, "rotate");
      applyStimulus(4'b1111, 1'b1, 4'b0000, 2'(o % 4), 1'b1, "rotateTurn");
    end

    // Steer rr_ptr to 2, then drop req[2] mid-grant.
    applyStimulus(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0, "steer");
    applyStimulus(4'b0100, 1'b1, 4'b0000, 2'd1, 1'b1, "steerTurn");
    applyStimulus(4'b1100, 1'b1, 4'b0100, 2'd2, 1'b0, "owner2");
    applyStimulus(4'b1100, 1'b1, 4'b0100, 2'd2, 1'b0, "owner2");
    applyStimulus(4'b1000, 1'b1, 4'b0000, 2'd2, 1'b1, "dropTurn");
    applyStimulus(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0, "owner3");

    // Pointer wraps from 3 back to 0.
    for (int c = 0; c < 3; c++) applyStimulus(4'b1001, 1'b1, 4'b1000, 2'd3, 1'b0, "wrapHold");
    applyStimulus(4'b1001, 1'b1, 4'b0000, 2'd3, 1'b1, "wrapTurn");
    applyStimulus(4'b1001, 1'b1, 4'b0001, 2'd0, 1'b0, "wrapGrant");
    applyStimulus(4'b1001, 1'b1, 4'b0001, 2'd0, 1'b0, "wrapGrant");

    // Enable dropped mid-grant: turnaround then idle despite requests.
    applyStimulus(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b1, "enOffTurn");
    applyStimulus(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, "enOffIdle");
    applyStimulus(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, "enOffIdle");
    applyStimulus(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, "enOffIdle");
    applyStimulus(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0, "enOn");
    applyStimulus(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0, "enOn");

    // Reset mid-grant, then confirm the pointer restarted at channel 0.
    applyReset("resetMidGrant");
    applyStimulus(4'b1001, 1'b1, 4'b0001, 2'd0, 1'b0, "ptrReset");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
